// File: rtl/lu_bitserial_driver.sv
// ---------------------------------------------------------------------------
// lu_bitserial_driver
//
// Drives a 4-bit logic operation through an external 1-bit logic unit (LU),
// one bit per cycle, LSB first, and returns the assembled 4-bit result.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous, active-low reset
//   req_valid/ready  request handshake; req_a, req_b, req_op are captured
//                    at the accepting edge
//   req_op           bit1 = group (1 AND/NAND, 0 OR/NOR), bit0 = invert
//   lu_a, lu_b       operand bits presented to the external LU (registered)
//   lu_select_group  op[1] while shifting, 0 otherwise
//   lu_select_op     op[0] while shifting, 0 otherwise
//   lu_s             combinational result bit from the external LU
//   rsp_valid/ready  response handshake
//   rsp_result       assembled result; holds its value until the next result
//   rsp_mismatch     internal reference disagrees with rsp_result (RESP only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid is held until that edge; ready never depends on valid.
//
// Configuration
//   LU_DRV_SELFCHECK_EN  when defined, an internal reference result is
//                        computed from the captured operands and compared
//                        against the LU result; otherwise rsp_mismatch is 0.
//
// The FSM state register `state` (IDLE/SHIFT/RESP) and bit counter `cnt`
// are plain named signals for hierarchical observation.
// ---------------------------------------------------------------------------
module lu_bitserial_driver (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_op,
  output logic       lu_a,
  output logic       lu_b,
  output logic       lu_select_op,
  output logic       lu_select_group,
  input  logic       lu_s,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e     state;
  state_e     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_inc;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [2:0] acc_q;
  logic [3:0] result_q;
  logic       lu_a_q;
  logic       lu_b_q;
  logic       req_ready_q;
  logic       accept;
  logic       last_bit;

  assign accept   = (state == IDLE) && req_ready_q && req_valid;
  assign last_bit = (state == SHIFT) && (cnt == 2'd3);
  assign cnt_inc  = cnt + 2'd1;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == 2'd3) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register. req_ready is registered from the next state so it is a
  // clean flop output that is 0 in reset and 1 from the first edge after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready_q <= (state_nxt == IDLE);
    end
  end

  // Datapath. lu_a/lu_b are loaded one cycle ahead of use: bit 0 at the
  // accepting edge, bit k+1 at the edge that samples bit k. The partial
  // result shifts in from the top so that after three samples acc_q holds
  // {b2,b1,b0}; the final sample completes the word straight into result_q,
  // so rsp_result only ever changes at the edge entering RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 2'd0;
      cnt      <= 2'd0;
      acc_q    <= 3'd0;
      result_q <= 4'd0;
      lu_a_q   <= 1'b0;
      lu_b_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= req_a;
      b_q    <= req_b;
      op_q   <= req_op;
      cnt    <= 2'd0;
      lu_a_q <= req_a[0];
      lu_b_q <= req_b[0];
    end else if (state == SHIFT) begin
      cnt <= cnt_inc;
      if (last_bit) begin
        result_q <= {lu_s, acc_q};
        lu_a_q   <= 1'b0;
        lu_b_q   <= 1'b0;
      end else begin
        acc_q  <= {lu_s, acc_q[2:1]};
        lu_a_q <= a_q[cnt_inc];
        lu_b_q <= b_q[cnt_inc];
      end
    end
  end

`ifdef LU_DRV_SELFCHECK_EN
  logic [3:0] ref_result;
  logic       mismatch_q;

  assign ref_result = (op_q[1] ? (a_q & b_q) : (a_q | b_q)) ^ {4{op_q[0]}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q <= 1'b0;
    end else if (last_bit) begin
      mismatch_q <= ({lu_s, acc_q} != ref_result);
    end
  end

  assign rsp_mismatch = mismatch_q && (state == RESP);
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready       = req_ready_q;
  assign rsp_valid       = (state == RESP);
  assign rsp_result      = result_q;
  assign lu_a            = lu_a_q;
  assign lu_b            = lu_b_q;
  assign lu_select_group = (state == SHIFT) && op_q[1];
  assign lu_select_op    = (state == SHIFT) && op_q[0];

endmodule

// File: tb/tb_lu_bitserial_driver.sv
// ---------------------------------------------------------------------------
// tb_lu_bitserial_driver
//
// Self-checking bench for lu_bitserial_driver. Contains an external 1-bit LU
// model (with a stuck-at-0 option), a transaction-level reference model
// compared against all outputs every cycle, a scoreboard of hand-computed
// expected results, and directed scenarios.
// ---------------------------------------------------------------------------
module tb_lu_bitserial_driver;

`ifdef LU_DRV_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_op;
  logic       lu_a;
  logic       lu_b;
  logic       lu_select_op;
  logic       lu_select_group;
  logic       lu_s;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_mismatch;

  always #5 clk = ~clk;

  lu_bitserial_driver dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_op          (req_op),
    .lu_a            (lu_a),
    .lu_b            (lu_b),
    .lu_select_op    (lu_select_op),
    .lu_select_group (lu_select_group),
    .lu_s            (lu_s),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_mismatch    (rsp_mismatch)
  );

  // External LU: group selects AND vs OR, op inverts.
  logic lu_stuck;
  assign lu_s = lu_stuck ? 1'b0
              : ((lu_select_group ? (lu_a & lu_b) : (lu_a | lu_b)) ^ lu_select_op);

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [3:0] r;
    r = op[1] ? (a & b) : (a | b);
    if (op[0]) r = ~r;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // m_t: 0 = idle, 1..4 = presenting operand bit m_t-1, 5 = response held.
  int         m_t     = 0;
  bit         m_ready = 1'b0;
  logic [3:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  bit         m_stuck;
  bit         chk_en  = 1'b0;
  logic [9:0] exp_v, act_v;
  bit         in_sh;

  initial begin
    m_a = 4'd0; m_b = 4'd0; m_op = 2'd0; m_res = 4'd0; m_stuck = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset_n) begin
        m_t = 0; m_ready = 1'b0; m_res = 4'd0;
      end
      in_sh = (m_t >= 1) && (m_t <= 4);
      exp_v = {m_ready, (m_t == 5),
               in_sh ? m_a[m_t-1] : 1'b0,
               in_sh ? m_b[m_t-1] : 1'b0,
               in_sh ? m_op[1] : 1'b0,
               in_sh ? m_op[0] : 1'b0,
               m_res,
               (m_t == 5) && SELFCHECK && (m_res != ref_op(m_a, m_b, m_op))};
      act_v = {req_ready, rsp_valid, lu_a, lu_b, lu_select_group, lu_select_op,
               rsp_result, rsp_mismatch};
      check("cycle_outputs", {6'd0, act_v}, {6'd0, exp_v});

      // scoreboard: transfer happens at the coming edge
      if (reset_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else check("scoreboard_result", {12'd0, rsp_result}, {12'd0, exp_q.pop_front()});
      end

      // advance model across the coming edge
      if (reset_n) begin
        if (m_t == 0) begin
          if (m_ready && req_valid) begin
            m_a = req_a; m_b = req_b; m_op = req_op; m_stuck = lu_stuck; m_t = 1;
          end
        end else if (m_t <= 3) begin
          m_t++;
        end else if (m_t == 4) begin
          m_t = 5;
          m_res = m_stuck ? 4'd0 : ref_op(m_a, m_b, m_op);
        end else if (rsp_ready) begin
          m_t = 0;
        end
        m_ready = (m_t == 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input bit push, input logic [3:0] exp);
    bit ok;
    ok = 1'b0;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    // scramble operands after acceptance; they must have no effect
    req_valid = 1'b0;
    req_a  = 4'($urandom_range(0, 15));
    req_b  = 4'($urandom_range(0, 15));
    req_op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) fail_now("rsp_timeout");
  endtask

  // ---------------- stimulus ----------------
  int seen_valid;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; lu_stuck = 1'b0;
    req_a = 4'd0; req_b = 4'd0; req_op = 2'd0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", {6'd0, req_ready, rsp_valid, lu_a, lu_b, lu_select_group,
                            lu_select_op, rsp_result, rsp_mismatch}, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // AND with latency pinned: valid low after E3, high after E4
    send(4'b1010, 4'b0110, 2'b10, 1'b1, 4'b0010);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("valid_before_e4", {15'd0, rsp_valid}, 16'd0);
    @(negedge clk);
    check("valid_at_e4", {15'd0, rsp_valid}, 16'd1);
    check("and_result", {12'd0, rsp_result}, {12'd0, 4'b0010});

    // back-to-back NAND, OR, NOR with rsp_ready held at 1
    send(4'b1010, 4'b0110, 2'b11, 1'b1, 4'b1101);
    wait_rsp();
    check("nand_result", {12'd0, rsp_result}, {12'd0, 4'b1101});
    send(4'b1010, 4'b0110, 2'b00, 1'b1, 4'b1110);
    wait_rsp();
    check("or_result", {12'd0, rsp_result}, {12'd0, 4'b1110});
    send(4'b1010, 4'b0110, 2'b01, 1'b1, 4'b0001);
    wait_rsp();
    check("nor_result", {12'd0, rsp_result}, {12'd0, 4'b0001});

    // response stall with an ignored request pulse
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(4'b1010, 4'b0110, 2'b10, 1'b1, 4'b0010);
    wait_rsp();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = (i == 1);
      req_a = 4'b1111; req_b = 4'b1111; req_op = 2'b01;
      @(negedge clk);
      check("stall_valid", {15'd0, rsp_valid}, 16'd1);
      check("stall_result", {12'd0, rsp_result}, {12'd0, 4'b0010});
      check("stall_req_ready", {15'd0, req_ready}, 16'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_rsp", {15'd0, req_ready}, 16'd1);

    // reset in the middle of shifting (k = 2)
    send(4'b1010, 4'b0110, 2'b10, 1'b0, 4'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {6'd0, req_ready, rsp_valid, lu_a, lu_b, lu_select_group,
                            lu_select_op, rsp_result, rsp_mismatch}, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    check("no_rsp_after_abort", 16'(seen_valid), 16'd0);
    send(4'b1111, 4'b0000, 2'b00, 1'b1, 4'b1111);
    wait_rsp();
    check("post_reset_or", {12'd0, rsp_result}, {12'd0, 4'b1111});

    // LU stuck at 0: NOR of 0001/0000 should be 1110 but comes back 0000
    @(posedge clk); #1 lu_stuck = 1'b1;
    send(4'b0001, 4'b0000, 2'b01, 1'b1, 4'b0000);
    wait_rsp();
    check("stuck_result", {12'd0, rsp_result}, {12'd0, 4'b0000});
    check("stuck_mismatch", {15'd0, rsp_mismatch}, {15'd0, SELFCHECK});
    @(posedge clk); #1 lu_stuck = 1'b0;

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
